jam_cost_table: RTL and testbench

Responder side of the job-assignment cost interface. Holds the 8×8 worker/job cost matrix, loaded once over a valid/ready stream. Answers the solver's (W, J) queries with Cost in the same cycle. Captures the solver's final MatchCount/MinCost when it raises Valid, and counts solver cycles for throughput checks.

---
 rtl/jam_pkg.sv | 25 ++
 rtl/jam_cost_mem.sv | 35 +++
 rtl/jam_cost_table.sv | 148 ++++++++++++++
 tb/tb_jam_cost_table.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jam_pkg.sv
// jam_pkg: constants and types shared by the cost table, the solver and the bench.
//   N_WORKERS  : matrix dimension (workers == jobs)
//   COST_W     : width of one cost entry
//   IDX_W      : width of a worker/job index
//   MCOUNT_W   : width of the solver's MatchCount result
//   MCOST_W    : width of the solver's MinCost result
//   state_t    : responder FSM states LOAD / SERVE / DONE
package jam_pkg;

    localparam int IDX_W     = 3;
    localparam int N_WORKERS = 2 ** IDX_W;
    localparam int COST_W    = 7;
    localparam int N_ENTRIES = N_WORKERS * N_WORKERS;
    localparam int ADDR_W    = 2 * IDX_W;
    localparam int MCOUNT_W  = 4;
    localparam int MCOST_W   = 10;
    localparam int CYC_W_DEF = 20;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/jam_cost_mem.sv
// jam_cost_mem: cost matrix storage, one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
//   i_clk   : write clock
//   i_we    : write enable
//   i_waddr : write address (row-major, W*N+J)
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, same cycle as i_raddr
module jam_cost_mem #(
    parameter int COST_W = 7,
    parameter int ADDR_W = 6
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [COST_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [COST_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [COST_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The solver accumulates Cost on the edge after it presents W/J, so the
    // read must be combinational.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/jam_cost_table.sv
// jam_cost_table: responder side of the job-assignment cost interface.
// Loads the N x N cost matrix over a valid/ready stream, serves combinational
// (W, J) cost reads to the solver, captures the solver's final result and
// counts the cycles spent serving.
//
// Ports:
//   CLK, RST        : clock, asynchronous active-high reset
//   load_valid/ready: load stream; load_data is one cost entry, row-major
//   reload          : one-cycle pulse, restart the load phase
//   table_ready     : all entries loaded, solver may run
//   W, J, Cost      : combinational table read (0 while loading)
//   Valid           : solver result strobe with MatchCount / MinCost
//   done            : result captured
//   res_count/cost  : captured MatchCount / MinCost
//   cycles          : edges spent in SERVE, saturating
//   o_dbg_state     : current FSM state (state_t encoding)
//
// Handshake: a load beat transfers on a rising edge where load_valid and
// load_ready are both high; load_ready depends only on state, never on
// load_valid. A reload in the same cycle overrides the beat, so the source
// must not drive load_valid together with reload.
module jam_cost_table #(
    parameter int COST_W = jam_pkg::COST_W,
    parameter int IDX_W  = jam_pkg::IDX_W,
    parameter int CYC_W  = jam_pkg::CYC_W_DEF
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         load_valid,
    input  logic [COST_W-1:0]            load_data,
    output logic                         load_ready,
    input  logic                         reload,
    output logic                         table_ready,
    input  logic [IDX_W-1:0]             W,
    input  logic [IDX_W-1:0]             J,
    output logic [COST_W-1:0]            Cost,
    input  logic                         Valid,
    input  logic [jam_pkg::MCOUNT_W-1:0] MatchCount,
    input  logic [jam_pkg::MCOST_W-1:0]  MinCost,
    output logic                         done,
    output logic [jam_pkg::MCOUNT_W-1:0] res_count,
    output logic [jam_pkg::MCOST_W-1:0]  res_cost,
    output logic [CYC_W-1:0]             cycles,
    output logic [1:0]                   o_dbg_state
);

    import jam_pkg::*;

    localparam int TADDR_W = 2 * IDX_W;

    state_t                r_state;
    logic [TADDR_W-1:0]    r_addr;
    logic                  r_load_ready;
    logic                  r_table_ready;
    logic                  r_done;
    logic [MCOUNT_W-1:0]   r_res_count;
    logic [MCOST_W-1:0]    r_res_cost;
    logic [CYC_W-1:0]      r_cycles;

    logic                  w_beat;
    logic                  w_last_beat;
    logic [TADDR_W-1:0]    w_raddr;
    logic [COST_W-1:0]     w_rdata;

    // reload suppresses the write so a dropped beat never lands in the table.
    assign w_beat      = (r_state == LOAD) && load_valid && !reload;
    assign w_last_beat = (r_addr == {TADDR_W{1'b1}});
    assign w_raddr     = {W, J};

    jam_cost_mem #(
        .COST_W (COST_W),
        .ADDR_W (TADDR_W)
    ) u_mem (
        .i_clk   (CLK),
        .i_we    (w_beat),
        .i_waddr (r_addr),
        .i_wdata (load_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state       <= LOAD;
            r_addr        <= '0;
            r_load_ready  <= 1'b1;
            r_table_ready <= 1'b0;
            r_done        <= 1'b0;
            r_res_count   <= '0;
            r_res_cost    <= '0;
            r_cycles      <= '0;
        end else if (reload) begin
            // Result registers survive a reload; only a new capture replaces them.
            r_state       <= LOAD;
            r_addr        <= '0;
            r_load_ready  <= 1'b1;
            r_table_ready <= 1'b0;
            r_done        <= 1'b0;
            r_cycles      <= '0;
        end else begin
            unique case (r_state)
                LOAD: begin
                    if (load_valid) begin
                        if (w_last_beat) begin
                            r_addr        <= '0;
                            r_state       <= SERVE;
                            r_load_ready  <= 1'b0;
                            r_table_ready <= 1'b1;
                            r_cycles      <= '0;
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                SERVE: begin
                    // The capture edge itself is counted.
                    if (r_cycles != {CYC_W{1'b1}}) begin
                        r_cycles <= r_cycles + 1'b1;
                    end
                    if (Valid) begin
                        r_res_count <= MatchCount;
                        r_res_cost  <= MinCost;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // First capture is final; everything holds until reload.
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

    assign load_ready  = r_load_ready;
    assign table_ready = r_table_ready;
    assign done        = r_done;
    assign res_count   = r_res_count;
    assign res_cost    = r_res_cost;
    assign cycles      = r_cycles;
    assign o_dbg_state = r_state;

    // Entries may be stale or half-written while loading, so hide them.
    assign Cost = (r_state == LOAD) ? '0 : w_rdata;

endmodule

// File: tb/tb_jam_cost_table.sv
module tb_jam_cost_table;

    import jam_pkg::*;

    localparam int CYC_W = 20;

    localparam logic [3:0] K_COST  = 4'd0;
    localparam logic [3:0] K_LRDY  = 4'd1;
    localparam logic [3:0] K_TRDY  = 4'd2;
    localparam logic [3:0] K_DONE  = 4'd3;
    localparam logic [3:0] K_RCNT  = 4'd4;
    localparam logic [3:0] K_RCOST = 4'd5;
    localparam logic [3:0] K_CYC   = 4'd6;
    localparam logic [3:0] K_STATE = 4'd7;

    // ---------------- DUT signals ----------------
    logic                 CLK;
    logic                 RST;
    logic                 load_valid;
    logic [COST_W-1:0]    load_data;
    logic                 load_ready;
    logic                 reload;
    logic                 table_ready;
    logic [IDX_W-1:0]     W;
    logic [IDX_W-1:0]     J;
    logic [COST_W-1:0]    Cost;
    logic                 Valid;
    logic [MCOUNT_W-1:0]  MatchCount;
    logic [MCOST_W-1:0]   MinCost;
    logic                 done;
    logic [MCOUNT_W-1:0]  res_count;
    logic [MCOST_W-1:0]   res_cost;
    logic [CYC_W-1:0]     cycles;
    logic [1:0]           dbg_state;

    jam_cost_table #(
        .COST_W (COST_W),
        .IDX_W  (IDX_W),
        .CYC_W  (CYC_W)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .reload      (reload),
        .table_ready (table_ready),
        .W           (W),
        .J           (J),
        .Cost        (Cost),
        .Valid       (Valid),
        .MatchCount  (MatchCount),
        .MinCost     (MinCost),
        .done        (done),
        .res_count   (res_count),
        .res_cost    (res_cost),
        .cycles      (cycles),
        .o_dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- scoreboard state ----------------
    logic [35:0]      exp_q[$];   // {kind, expected value}
    logic [13:0]      cap_q[$];   // {MatchCount, MinCost} expected at done rise
    int               n_tests = 0;
    int               n_fail  = 0;
    logic             done_q  = 1'b0;

    logic [COST_W-1:0] tbl [N_ENTRIES];
    int                m_st;
    int                m_cyc;

    function automatic string kname(input logic [3:0] k);
        case (k)
            K_COST:  return "cost";
            K_LRDY:  return "load_ready";
            K_TRDY:  return "table_ready";
            K_DONE:  return "done";
            K_RCNT:  return "res_count";
            K_RCOST: return "res_cost";
            K_CYC:   return "cycles";
            default: return "state";
        endcase
    endfunction

    function automatic logic [31:0] actual_of(input logic [3:0] k);
        case (k)
            K_COST:  return 32'(Cost);
            K_LRDY:  return 32'(load_ready);
            K_TRDY:  return 32'(table_ready);
            K_DONE:  return 32'(done);
            K_RCNT:  return 32'(res_count);
            K_RCOST: return 32'(res_cost);
            K_CYC:   return 32'(cycles);
            default: return 32'(dbg_state);
        endcase
    endfunction

    function automatic void push(input logic [3:0] k, input int v);
        exp_q.push_back({k, 32'(v)});
    endfunction

    // ---------------- monitor ----------------
    always @(negedge CLK) begin : monitor
        logic [35:0] it;
        logic [13:0] cp;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            it  = exp_q.pop_front();
            act = actual_of(it[35:32]);
            n_tests++;
            if (act !== it[31:0]) begin
                n_fail++;
                $display("FAIL %s: got %0d expected %0d at %0t",
                         kname(it[35:32]), act, it[31:0], $time);
            end
        end
        if (done && !done_q) begin
            n_tests++;
            if (cap_q.size() == 0) begin
                n_fail++;
                $display("FAIL capture_unexpected: got done=1 expected no capture at %0t", $time);
            end else begin
                cp = cap_q.pop_front();
                if (res_count !== cp[13:10] || res_cost !== cp[9:0]) begin
                    n_fail++;
                    $display("FAIL capture: got count=%0d cost=%0d expected count=%0d cost=%0d",
                             res_count, res_cost, cp[13:10], cp[9:0]);
                end
            end
        end
        done_q = done;
    end

    // ---------------- driver tasks ----------------
    // One clock edge; the tiny model tracks state and the SERVE edge count.
    task automatic tick();
        @(posedge CLK);
        if (reload) begin
            m_st  = LOAD;
            m_cyc = 0;
        end else if (m_st == SERVE) begin
            if (m_cyc != (2 ** CYC_W) - 1) m_cyc++;
            if (Valid) m_st = DONE;
        end
        #1;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
    endtask

    task automatic load_table(input int gap);
        for (int i = 0; i < N_ENTRIES; i++) begin
            if (gap != 0) begin
                load_valid = 1'b0;
                tick();
                tick();
            end
            load_valid = 1'b1;
            load_data  = tbl[i];
            if (i == 30) begin
                W = 3'd5;
                J = 3'd2;
                push(K_COST, 0);
                push(K_TRDY, 0);
                push(K_STATE, LOAD);
            end
            tick();
        end
        load_valid = 1'b0;
        m_st  = SERVE;
        m_cyc = 0;
        push(K_TRDY, 1);
        push(K_LRDY, 0);
        push(K_CYC, 0);
        push(K_STATE, SERVE);
    endtask

    task automatic sweep(input int step);
        for (int idx = 0; idx < N_ENTRIES; idx += step) begin
            W = idx[5:3];
            J = idx[2:0];
            push(K_COST, int'(tbl[idx]));
            tick();
        end
    endtask

    task automatic capture(input logic [3:0] mc, input logic [9:0] mcost);
        Valid      = 1'b1;
        MatchCount = mc;
        MinCost    = mcost;
        cap_q.push_back({mc, mcost});
        tick();
        Valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        RST = 1'b1; load_valid = 1'b0; load_data = '0; reload = 1'b0;
        W = '0; J = '0; Valid = 1'b0; MatchCount = '0; MinCost = '0;
        m_st = LOAD; m_cyc = 0;
        #1;
        // Reset values
        push(K_LRDY, 1); push(K_TRDY, 0); push(K_DONE, 0); push(K_RCNT, 0);
        push(K_RCOST, 0); push(K_CYC, 0); push(K_COST, 0); push(K_STATE, LOAD);
        tick(); tick();
        RST = 1'b0;
        tick();

        // Ramp table, continuous valid, full sweep: Cost = W*8+J
        for (int i = 0; i < N_ENTRIES; i++) tbl[i] = 7'(i);
        load_table(0);
        sweep(1);

        // Gapped load of 127-i, then extra beats in SERVE must not write
        do_reload();
        push(K_TRDY, 0); push(K_LRDY, 1); push(K_STATE, LOAD);
        for (int i = 0; i < N_ENTRIES; i++) tbl[i] = 7'(127 - i);
        load_table(1);
        load_valid = 1'b1;
        load_data  = 7'h55;
        tick(); tick(); tick();
        load_valid = 1'b0;
        W = 3'd7; J = 3'd7; push(K_COST, 64);  tick();
        W = 3'd0; J = 3'd0; push(K_COST, 127); tick();
        W = 3'd0; J = 3'd1; push(K_COST, 126); tick();

        // Identity cost: diagonal 1, others 100
        do_reload();
        for (int i = 0; i < N_ENTRIES; i++) tbl[i] = (i[5:3] == i[2:0]) ? 7'd1 : 7'd100;
        load_table(0);
        W = 3'd3; J = 3'd3; push(K_COST, 1);   tick();
        W = 3'd3; J = 3'd4; push(K_COST, 100); tick();
        capture(4'd1, 10'd8);
        push(K_DONE, 1); push(K_RCNT, 1); push(K_RCOST, 8);
        push(K_CYC, 3); push(K_STATE, DONE);
        tick(); tick(); tick();
        push(K_CYC, 3);
        W = 3'd1; J = 3'd1; push(K_COST, 1); tick();

        // All 5: MinCost 40, second Valid after DONE ignored
        do_reload();
        push(K_DONE, 0); push(K_RCOST, 8);
        for (int i = 0; i < N_ENTRIES; i++) tbl[i] = 7'd5;
        load_table(0);
        tick();
        capture(4'd8, 10'd40);
        push(K_RCNT, 8); push(K_RCOST, 40); push(K_DONE, 1); push(K_CYC, 2);
        Valid = 1'b1; MatchCount = 4'd3; MinCost = 10'd99;
        tick();
        Valid = 1'b0;
        push(K_RCNT, 8); push(K_RCOST, 40); push(K_DONE, 1); push(K_STATE, DONE);

        // Reload, load, then reload mid-SERVE and serve a new table
        do_reload();
        push(K_TRDY, 0); push(K_DONE, 0); push(K_RCOST, 40); push(K_CYC, 0);
        for (int i = 0; i < N_ENTRIES; i++) tbl[i] = 7'((i * 3) % 128);
        load_table(0);
        sweep(9);
        do_reload();
        push(K_TRDY, 0); push(K_CYC, 0); push(K_RCOST, 40); push(K_STATE, LOAD);
        for (int i = 0; i < N_ENTRIES; i++) tbl[i] = 7'(i ^ 42);
        load_table(0);
        sweep(5);
        push(K_CYC, m_cyc); push(K_CYC, 13); push(K_RCOST, 40); push(K_RCNT, 8);
        tick();
        // reload together with Valid in SERVE: nothing captured
        reload = 1'b1; Valid = 1'b1; MatchCount = 4'd2; MinCost = 10'd77;
        tick();
        reload = 1'b0; Valid = 1'b0;
        push(K_DONE, 0); push(K_RCOST, 40); push(K_RCNT, 8); push(K_STATE, LOAD);

        // Asynchronous reset between edges at beat 30
        for (int i = 0; i < N_ENTRIES; i++) tbl[i] = 7'(i);
        for (int i = 0; i < 30; i++) begin
            load_valid = 1'b1;
            load_data  = tbl[i];
            tick();
        end
        load_valid = 1'b1;
        load_data  = tbl[30];
        #2;
        RST = 1'b1;
        push(K_LRDY, 1); push(K_TRDY, 0); push(K_DONE, 0); push(K_RCNT, 0);
        push(K_RCOST, 0); push(K_CYC, 0); push(K_COST, 0); push(K_STATE, LOAD);
        tick();
        RST = 1'b0;
        load_valid = 1'b0;
        m_st = LOAD; m_cyc = 0;
        tick();
        push(K_LRDY, 1); push(K_TRDY, 0);
        load_table(0);
        sweep(7);
        capture(4'd5, 10'd300);
        push(K_DONE, 1); push(K_RCNT, 5); push(K_RCOST, 300); push(K_CYC, 11);
        tick(); tick();

        // Every expectation must have been consumed
        n_tests++;
        if (exp_q.size() != 0 || cap_q.size() != 0) begin
            n_fail++;
            $display("FAIL queues_drained: got exp=%0d cap=%0d expected 0 0",
                     exp_q.size(), cap_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
